// File: rtl/cle_pkg.sv
// Shared constants and types for the label statistics stage of the
// connected-component labeling engine.
package cle_pkg;

  localparam int unsigned IMG_ROWS   = 32;
  localparam int unsigned IMG_COLS   = 32;
  localparam int unsigned IMG_PIXELS = IMG_ROWS * IMG_COLS;
  localparam int unsigned LABEL_BITS = 3;
  localparam int unsigned MAX_LABEL  = (1 << LABEL_BITS) - 1;
  localparam int unsigned ADDR_BITS  = $clog2(IMG_PIXELS);
  localparam int unsigned CNT_BITS   = ADDR_BITS + 1;
  localparam int unsigned COORD_BITS = $clog2(IMG_ROWS);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDrain,
    StEmit,
    StDone
  } state_e;

  typedef struct packed {
    logic [LABEL_BITS-1:0] label;
    logic [CNT_BITS-1:0]   count;
    logic [COORD_BITS-1:0] rmin;
    logic [COORD_BITS-1:0] rmax;
    logic [COORD_BITS-1:0] cmin;
    logic [COORD_BITS-1:0] cmax;
  } rec_t;

endpackage

// File: rtl/cle_label_stats_if.sv
// Label SRAM read port plus the valid/ready record stream of cle_label_stats.
interface cle_label_stats_if;
  import cle_pkg::*;

  logic [ADDR_BITS-1:0]  sram_a;
  logic [7:0]            sram_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [LABEL_BITS-1:0] out_label;
  logic [CNT_BITS-1:0]   out_count;
  logic [COORD_BITS-1:0] out_rmin;
  logic [COORD_BITS-1:0] out_rmax;
  logic [COORD_BITS-1:0] out_cmin;
  logic [COORD_BITS-1:0] out_cmax;

  modport master (
    output sram_a, out_valid, out_label, out_count, out_rmin, out_rmax, out_cmin, out_cmax,
    input  sram_q, out_ready
  );

  modport slave (
    input  sram_a, out_valid, out_label, out_count, out_rmin, out_rmax, out_cmin, out_cmax,
    output sram_q, out_ready
  );

endinterface

// File: rtl/cle_bbox_acc.sv
// Pixel count and bounding-box accumulator for a single label.
module cle_bbox_acc
  import cle_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  upd,
  input  logic [COORD_BITS-1:0] row,
  input  logic [COORD_BITS-1:0] col,
  output logic [CNT_BITS-1:0]   count,
  output logic [COORD_BITS-1:0] rmin,
  output logic [COORD_BITS-1:0] rmax,
  output logic [COORD_BITS-1:0] cmin,
  output logic [COORD_BITS-1:0] cmax
);

  typedef logic [CNT_BITS-1:0] cnt_t;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      rmin  <= COORD_BITS'(IMG_ROWS - 1);
      rmax  <= '0;
      cmin  <= COORD_BITS'(IMG_COLS - 1);
      cmax  <= '0;
    end else if (upd) begin
      count <= count + cnt_t'(1);
      if (row < rmin) rmin <= row;
      if (row > rmax) rmax <= row;
      if (col < cmin) cmin <= col;
      if (col > cmax) cmax <= col;
    end
  end

endmodule

// File: rtl/cle_label_stats.sv
// Scans the label SRAM once per start, accumulates per-label statistics and
// emits one record per non-empty label in ascending label order.
module cle_label_stats #(
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned COL_BITS   = 5,
  parameter int unsigned LABEL_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_label,
  cle_label_stats_if.master bus
);
  import cle_pkg::*;

  localparam int unsigned AddrBits  = ROW_BITS + COL_BITS;
  localparam int unsigned NumLabels = (1 << LABEL_BITS) - 1;

  typedef logic [AddrBits-1:0]   addr_t;
  typedef logic [LABEL_BITS-1:0] lab_t;

  localparam addr_t LastAddr = '1;

  state_e state_q, state_d;
  addr_t  addr_q;
  addr_t  a_q;       // address aligned with the sram_q now on the bus
  logic   rd_vld_q;
  logic   v_q;
  lab_t   ptr_q;
  logic   clr;

  logic [ROW_BITS-1:0] cap_row;
  logic [COL_BITS-1:0] cap_col;
  logic [NumLabels:1]  upd;

  logic [CNT_BITS-1:0] acc_cnt  [1:NumLabels];
  logic [ROW_BITS-1:0] acc_rmin [1:NumLabels];
  logic [ROW_BITS-1:0] acc_rmax [1:NumLabels];
  logic [COL_BITS-1:0] acc_cmin [1:NumLabels];
  logic [COL_BITS-1:0] acc_cmax [1:NumLabels];

  assign bus.sram_a = addr_q;
  assign cap_row    = a_q[AddrBits-1:COL_BITS];
  assign cap_col    = a_q[COL_BITS-1:0];
  assign clr        = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

  for (genvar g = 1; g <= NumLabels; g++) begin : g_acc
    assign upd[g] = v_q && (bus.sram_q == 8'(g));

    cle_bbox_acc u_acc (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .upd   (upd[g]),
      .row   (cap_row),
      .col   (cap_col),
      .count (acc_cnt[g]),
      .rmin  (acc_rmin[g]),
      .rmax  (acc_rmax[g]),
      .cmin  (acc_cmin[g]),
      .cmax  (acc_cmax[g])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (addr_q == LastAddr) state_d = StDrain;
      // The final capture lands on the same edge that leaves DRAIN.
      StDrain: state_d = StEmit;
      StEmit: begin
        if (ptr_q == lab_t'(NumLabels) &&
            (bus.out_valid ? bus.out_ready : (acc_cnt[ptr_q] == '0))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      a_q           <= '0;
      rd_vld_q      <= 1'b0;
      v_q           <= 1'b0;
      ptr_q         <= lab_t'(1);
      err_label     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_label <= '0;
      bus.out_count <= '0;
      bus.out_rmin  <= '0;
      bus.out_rmax  <= '0;
      bus.out_cmin  <= '0;
      bus.out_cmax  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= addr_q;
      v_q     <= rd_vld_q;
      if (v_q && (bus.sram_q > 8'(NumLabels))) err_label <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q    <= '0;
            rd_vld_q  <= 1'b1;
            ptr_q     <= lab_t'(1);
            err_label <= 1'b0;
          end
        end
        StScan: begin
          if (addr_q == LastAddr) rd_vld_q <= 1'b0;
          else                    addr_q   <= addr_q + addr_t'(1);
        end
        StEmit: begin
          if (bus.out_valid) begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              ptr_q         <= ptr_q + lab_t'(1);
            end
          end else if (acc_cnt[ptr_q] != '0) begin
            bus.out_valid <= 1'b1;
            bus.out_label <= ptr_q;
            bus.out_count <= acc_cnt[ptr_q];
            bus.out_rmin  <= acc_rmin[ptr_q];
            bus.out_rmax  <= acc_rmax[ptr_q];
            bus.out_cmin  <= acc_cmin[ptr_q];
            bus.out_cmax  <= acc_cmax[ptr_q];
          end else begin
            ptr_q <= ptr_q + lab_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cle_label_stats.sv
// Directed and randomized bench for cle_label_stats; expected records come from
// a direct per-label tally over the SRAM image.
module tb_cle_label_stats;
  import cle_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic err_label;

  cle_label_stats_if bus ();

  cle_label_stats #(
    .ROW_BITS   (5),
    .COL_BITS   (5),
    .LABEL_BITS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err_label (err_label),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [IMG_PIXELS];
  always @(posedge clk) bus.sram_q <= mem[bus.sram_a];

  int   vectors = 0;
  int   errors  = 0;
  rec_t exp_q[$];
  logic exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < IMG_PIXELS; i++) mem[i] = 8'h00;
  endtask

  task automatic block_image();
    clear_mem();
    for (int r = 3; r <= 5; r++)
      for (int c = 10; c <= 12; c++) mem[r * 32 + c] = 8'd2;
    mem[0] = 8'd5;
  endtask

  task automatic random_image();
    int p;
    for (int i = 0; i < IMG_PIXELS; i++) begin
      p = $urandom_range(0, 99);
      if (p < 60)      mem[i] = 8'h00;
      else if (p < 98) mem[i] = 8'($urandom_range(1, 7));
      else             mem[i] = 8'($urandom_range(8, 255));
    end
  endtask

  // Reference: tally every label directly over the whole image.
  task automatic build_model();
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < IMG_PIXELS; i++) if (mem[i] > 8'd7) exp_err = 1'b1;
    for (int lab = 1; lab <= 7; lab++) begin
      int   n, r0, r1, c0, c1;
      rec_t rec;
      n = 0; r0 = 99; r1 = -1; c0 = 99; c1 = -1;
      for (int i = 0; i < IMG_PIXELS; i++) begin
        if (mem[i] == 8'(lab)) begin
          n++;
          if (i / 32 < r0) r0 = i / 32;
          if (i / 32 > r1) r1 = i / 32;
          if (i % 32 < c0) c0 = i % 32;
          if (i % 32 > c1) c1 = i % 32;
        end
      end
      if (n > 0) begin
        rec.label = 3'(lab);
        rec.count = 11'(n);
        rec.rmin  = 5'(r0);
        rec.rmax  = 5'(r1);
        rec.cmin  = 5'(c0);
        rec.cmax  = 5'(c1);
        exp_q.push_back(rec);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err_label"}, err_label, 0);
    check({tag, " out_valid"}, bus.out_valid, 0);
    check({tag, " sram_a"}, bus.sram_a, 0);
    check({tag, " fields"}, {bus.out_label, bus.out_count, bus.out_rmin, bus.out_rmax,
                             bus.out_cmin, bus.out_cmax}, 0);
  endtask

  task automatic run_case(input string name, input int stall_cycles, input bit extra_start);
    int   stall, dones;
    bit   pending, ready_drv, seen_done;
    rec_t cur, held;
    build_model();
    pending   = 1'b0;
    stall     = 0;
    dones     = 0;
    seen_done = 1'b0;
    ready_drv = (stall_cycles == 0);
    bus.out_ready = ready_drv;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = extra_start && (cyc == 300);
      if (pending && ready_drv) begin
        pending = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.out_valid) begin
        cur.label = bus.out_label;
        cur.count = bus.out_count;
        cur.rmin  = bus.out_rmin;
        cur.rmax  = bus.out_rmax;
        cur.cmin  = bus.out_cmin;
        cur.cmax  = bus.out_cmax;
        if (!pending) begin
          pending = 1'b1;
          held    = cur;
          stall   = stall_cycles;
          if (exp_q.size() > 0) check({name, " record"}, cur, exp_q[0]);
          else                  check({name, " unexpected out_valid"}, bus.out_valid, 0);
        end else begin
          check({name, " stall hold"}, cur, held);
        end
        if (stall > 0) begin
          stall--;
          ready_drv = 1'b0;
        end else begin
          ready_drv = 1'b1;
        end
      end else begin
        ready_drv = (stall_cycles == 0);
      end
      bus.out_ready = ready_drv;
      if (seen_done) begin
        check({name, " busy after done"}, busy, 0);
        break;
      end
      if (done) begin
        dones++;
        seen_done = 1'b1;
      end
    end
    check({name, " finished in budget"}, seen_done, 1);
    if (extra_start) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) dones++;
      end
      check({name, " no queued start"}, busy, 0);
    end
    check({name, " done pulses"}, dones, 1);
    check({name, " records missing"}, exp_q.size(), 0);
    check({name, " err_label"}, err_label, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    clear_mem();
    run_case("all_zero", 0, 1'b0);

    clear_mem();
    mem[1023] = 8'd1;
    run_case("single_1023", 0, 1'b0);

    block_image();
    run_case("block", 0, 1'b0);

    block_image();
    run_case("block_stall", 5, 1'b0);

    clear_mem();
    mem[40] = 8'h09;
    run_case("bad_label", 0, 1'b0);

    // Abort a scan part-way and make sure nothing carries into the next run.
    random_image();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.sram_a == 10'd500) break;
    end
    check("abort reached addr", bus.sram_a, 500);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("abort reset");
    reset = 1'b0;
    clear_mem();
    mem[17] = 8'd3;
    run_case("after_abort", 0, 1'b0);

    block_image();
    run_case("double_start", 0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      random_image();
      run_case($sformatf("random%0d", t), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
